vdp_vram_arb: RTL and testbench

Single-port VRAM arbiter and SRAM timing controller for the TMS9918A-compatible VDP. It sits downstream of the CPU interface's `vram_cpu_*` request port and the display/sprite fetch engine's `vram_disp_*` port. It drives the external 16K x 8 asynchronous SRAM. Each request gets one SRAM access with fixed setup, strobe and hold phases, and completes with a one-cycle ack carrying read data.

---
 rtl/vdp_vram_arb_if.sv | 44 ++++
 rtl/vdp_vram_arb.sv | 169 ++++++++++++++++
 tb/tb_vdp_vram_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_vram_arb_if.sv
// VRAM arbiter bus: CPU and display request/ack ports plus the external SRAM pins.
// slave = arbiter side, master = requesters and SRAM side.
interface vdp_vram_arb_if;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;

    logic          vram_cpu_req;
    logic          vram_cpu_ack;
    logic          vram_cpu_wr;
    logic [AW-1:0] vram_cpu_a;
    logic [DW-1:0] vram_cpu_wdata;
    logic [DW-1:0] vram_cpu_rdata;

    logic          vram_disp_req;
    logic          vram_disp_ack;
    logic [AW-1:0] vram_disp_a;
    logic [DW-1:0] vram_disp_rdata;

    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_dout;
    logic [DW-1:0] sram_din;
    logic          sram_d_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    modport slave (
        input  vram_cpu_req, vram_cpu_wr, vram_cpu_a, vram_cpu_wdata,
        output vram_cpu_ack, vram_cpu_rdata,
        input  vram_disp_req, vram_disp_a,
        output vram_disp_ack, vram_disp_rdata,
        output sram_a, sram_dout, sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_din
    );

    modport master (
        output vram_cpu_req, vram_cpu_wr, vram_cpu_a, vram_cpu_wdata,
        input  vram_cpu_ack, vram_cpu_rdata,
        output vram_disp_req, vram_disp_a,
        input  vram_disp_ack, vram_disp_rdata,
        input  sram_a, sram_dout, sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_din
    );
endinterface

// File: rtl/vdp_vram_arb.sv
// VRAM arbiter and async SRAM timing controller: IDLE -> SETUP -> STROBE x ACC_CYCLES -> ACK.
// Define VDP_VRAM_ARB_FAIR_EN to alternate grants when both requesters contend.
module vdp_vram_arb #(
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic           clk40m,
    input  logic           rst,
    vdp_vram_arb_if.slave  vram_bus
);
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_ACK} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;   // 1 = display
    logic          wr_q, wr_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          d_oe_q, d_oe_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          disp_ack_q, disp_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] disp_rdata_q, disp_rdata_d;
    logic          req_any_c;
    logic          grant_disp_c;

`ifdef VDP_VRAM_ARB_FAIR_EN
    logic          last_disp_q;

    always_ff @(posedge clk40m or posedge rst) begin
        if (rst)                             last_disp_q <= 1'b0;
        else if (state_q == S_IDLE && req_any_c) last_disp_q <= grant_disp_c;
    end

    // CPU wins a contended grant right after a display grant
    always_comb begin
        req_any_c    = vram_bus.vram_cpu_req | vram_bus.vram_disp_req;
        grant_disp_c = vram_bus.vram_disp_req & ~(vram_bus.vram_cpu_req & last_disp_q);
    end
`else
    always_comb begin
        req_any_c    = vram_bus.vram_cpu_req | vram_bus.vram_disp_req;
        grant_disp_c = vram_bus.vram_disp_req;
    end
`endif

    always_ff @(posedge clk40m or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:   if (req_any_c) state_d = S_SETUP;
            S_SETUP:  begin
                state_d = S_STROBE;
                cnt_d   = CW'(ACC_CYCLES - 1);
            end
            S_STROBE: begin
                if (cnt_q == '0) state_d = S_ACK;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output registers are loaded from the state being entered, so pins change on the phase edge
    always_comb begin
        owner_d      = owner_q;
        wr_d         = wr_q;
        a_d          = a_q;
        dout_d       = dout_q;
        d_oe_d       = 1'b0;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        cpu_ack_d    = 1'b0;
        disp_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        disp_rdata_d = disp_rdata_q;

        if (state_q == S_IDLE && req_any_c) begin
            owner_d = grant_disp_c;
            wr_d    = ~grant_disp_c & vram_bus.vram_cpu_wr;
            a_d     = grant_disp_c ? vram_bus.vram_disp_a : vram_bus.vram_cpu_a;
            if (!grant_disp_c) dout_d = vram_bus.vram_cpu_wdata;
        end

        if (state_q == S_STROBE && state_d == S_ACK && !wr_q) begin
            if (owner_q) disp_rdata_d = vram_bus.sram_din;
            else         cpu_rdata_d  = vram_bus.sram_din;
        end

        unique case (state_d)
            S_SETUP:  begin
                ce_n_d = 1'b0;
                d_oe_d = wr_d;
            end
            S_STROBE: begin
                ce_n_d = 1'b0;
                d_oe_d = wr_q;
                oe_n_d = wr_q;
                we_n_d = ~wr_q;
            end
            S_ACK:    begin
                ce_n_d     = 1'b0;
                d_oe_d     = wr_q;
                cpu_ack_d  = ~owner_q;
                disp_ack_d = owner_q;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge clk40m or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b1;
            wr_q         <= 1'b0;
            a_q          <= '0;
            dout_q       <= '0;
            d_oe_q       <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            cpu_ack_q    <= 1'b0;
            disp_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            disp_rdata_q <= '0;
        end else begin
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            a_q          <= a_d;
            dout_q       <= dout_d;
            d_oe_q       <= d_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            cpu_ack_q    <= cpu_ack_d;
            disp_ack_q   <= disp_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            disp_rdata_q <= disp_rdata_d;
        end
    end

    assign vram_bus.vram_cpu_ack    = cpu_ack_q;
    assign vram_bus.vram_cpu_rdata  = cpu_rdata_q;
    assign vram_bus.vram_disp_ack   = disp_ack_q;
    assign vram_bus.vram_disp_rdata = disp_rdata_q;
    assign vram_bus.sram_a          = a_q;
    assign vram_bus.sram_dout       = dout_q;
    assign vram_bus.sram_d_oe       = d_oe_q;
    assign vram_bus.sram_ce_n       = ce_n_q;
    assign vram_bus.sram_oe_n       = oe_n_q;
    assign vram_bus.sram_we_n       = we_n_q;
endmodule

// File: tb/tb_vdp_vram_arb.sv
// Bench for vdp_vram_arb: SRAM memory plus an access-timeline model checked every cycle,
// with directed scenarios pinned by hand-computed literals.
`timescale 1ns/100ps
module tb_vdp_vram_arb;
    localparam int unsigned ACC = 2;
`ifdef VDP_VRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk40m = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #12.5 clk40m = ~clk40m;

    vdp_vram_arb_if bus ();

    vdp_vram_arb #(.ACC_CYCLES(ACC)) dut (
        .clk40m   (clk40m),
        .rst      (rst),
        .vram_bus (bus)
    );

    logic [7:0] mem [0:16383];
    assign bus.sram_din = mem[bus.sram_a];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an access is described by the number of edges k since its grant edge
    bit         m_busy = 1'b0;
    int         m_k = 0;
    bit         m_disp = 1'b0;
    bit         m_wr = 1'b0;
    logic [13:0] m_a = '0;
    logic [7:0]  m_wd = '0;
    logic [7:0]  m_cpu_rd = '0;
    logic [7:0]  m_disp_rd = '0;
    bit         m_last_disp = 1'b0;

    always @(posedge clk40m or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_k = 0; m_cpu_rd = '0; m_disp_rd = '0; m_last_disp = 1'b0;
        end else if (m_busy) begin
            m_k++;
            if (m_k == ACC + 1) begin
                if (m_wr)        mem[m_a]  = m_wd;
                else if (m_disp) m_disp_rd = mem[m_a];
                else             m_cpu_rd  = mem[m_a];
            end
            if (m_k == ACC + 2) m_busy = 1'b0;
        end else if (bus.vram_cpu_req || bus.vram_disp_req) begin
            m_disp      = bus.vram_disp_req && !(FAIR && bus.vram_cpu_req && m_last_disp);
            m_last_disp = m_disp;
            m_wr        = !m_disp && bus.vram_cpu_wr;
            m_a         = m_disp ? bus.vram_disp_a : bus.vram_cpu_a;
            m_wd        = bus.vram_cpu_wdata;
            m_busy      = 1'b1;
            m_k         = 0;
        end
    end

    int  we_low = 0;
    byte order_q[$];

    always @(negedge clk40m) begin
        bit sel, strobe;
        sel    = m_busy && m_k <= ACC + 1;
        strobe = m_busy && m_k >= 1 && m_k <= ACC;
        chk("ce_n", bus.sram_ce_n, !sel);
        chk("oe_n", bus.sram_oe_n, !(strobe && !m_wr));
        chk("we_n", bus.sram_we_n, !(strobe && m_wr));
        chk("d_oe", bus.sram_d_oe, sel && m_wr);
        chk("cpu_ack", bus.vram_cpu_ack, m_busy && m_k == ACC + 1 && !m_disp);
        chk("disp_ack", bus.vram_disp_ack, m_busy && m_k == ACC + 1 && m_disp);
        chk("cpu_rdata", bus.vram_cpu_rdata, m_cpu_rd);
        chk("disp_rdata", bus.vram_disp_rdata, m_disp_rd);
        if (sel) chk("sram_a", bus.sram_a, m_a);
        if (sel && m_wr) chk("sram_dout", bus.sram_dout, m_wd);
        if (!bus.sram_we_n) we_low++;
        if (bus.vram_disp_ack) order_q.push_back("D");
        if (bus.vram_cpu_ack)  order_q.push_back("C");
    end

    task automatic wait_ack(input bit disp, output int lat);
        bit done = 1'b0;
        lat = 0;
        while (!done) begin
            @(negedge clk40m);
            lat++;
            if (disp ? bus.vram_disp_ack : bus.vram_cpu_ack) done = 1'b1;
            else if (lat > 60) begin
                chk(disp ? "disp_ack_timeout" : "cpu_ack_timeout", lat, 0);
                done = 1'b1;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with req dropped (a following call re-raises it)
    task automatic cpu_acc(input bit wr, input logic [13:0] a, input logic [7:0] wd, output int lat);
        bus.vram_cpu_req   = 1'b1;
        bus.vram_cpu_wr    = wr;
        bus.vram_cpu_a     = a;
        bus.vram_cpu_wdata = wd;
        wait_ack(1'b0, lat);
        @(posedge clk40m); #1;
        bus.vram_cpu_req = 1'b0;
    endtask

    task automatic disp_acc(input logic [13:0] a, output int lat);
        bus.vram_disp_req = 1'b1;
        bus.vram_disp_a   = a;
        wait_ack(1'b1, lat);
        @(posedge clk40m); #1;
        bus.vram_disp_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat, lat2;
        string exp_s;
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 37 + 5);
        mem[14'h0800] = 8'h3C;
        mem[14'h0010] = 8'h11;
        mem[14'h0020] = 8'h22;
        bus.vram_cpu_req = 1'b0; bus.vram_cpu_wr = 1'b0; bus.vram_cpu_a = '0; bus.vram_cpu_wdata = '0;
        bus.vram_disp_req = 1'b0; bus.vram_disp_a = '0;
        rst = 1'b1;
        #3;
        chk("rst_ce_n", bus.sram_ce_n, 1);
        chk("rst_we_n", bus.sram_we_n, 1);
        chk("rst_oe_n", bus.sram_oe_n, 1);
        chk("rst_d_oe", bus.sram_d_oe, 0);
        chk("rst_sram_a", bus.sram_a, 0);
        chk("rst_sram_dout", bus.sram_dout, 0);
        chk("rst_acks", {bus.vram_cpu_ack, bus.vram_disp_ack}, 0);
        chk("rst_rdata", {bus.vram_cpu_rdata, bus.vram_disp_rdata}, 0);
        repeat (2) @(posedge clk40m);
        #1 rst = 1'b0;
        @(posedge clk40m); #1;

        // CPU write: 2 clocks of we_n low, ack on the 5th clock
        we_low = 0;
        cpu_acc(1'b1, 14'h1234, 8'hA5, lat);
        chk("wr_ack_latency", lat, 5);
        chk("wr_we_low_clocks", we_low, 2);
        chk("wr_cpu_rdata_held", bus.vram_cpu_rdata, 8'h00);

        // CPU read of 0x0800 returns 0x3C; display rdata untouched
        cpu_acc(1'b0, 14'h0800, 8'h00, lat);
        chk("rd_ack_latency", lat, 5);
        chk("rd_cpu_rdata", bus.vram_cpu_rdata, 8'h3C);
        chk("rd_disp_rdata_held", bus.vram_disp_rdata, 8'h00);
        cpu_acc(1'b0, 14'h1234, 8'h00, lat);
        chk("rd_back_written", bus.vram_cpu_rdata, 8'hA5);

        // Contention: both ports held high
        order_q.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) disp_acc(14'(16'h0100 + i), lat2);
            end
            begin
                for (int i = 0; i < 2; i++) cpu_acc(1'b0, 14'(16'h0200 + i), 8'h00, lat2);
            end
        join
        exp_s = FAIR ? "DCDC" : "DDDD";
        chk("order_len", order_q.size(), 6);
        for (int i = 0; i < 4; i++)
            if (i < order_q.size()) chk($sformatf("order_%0d", i), order_q[i], exp_s[i]);
        chk("contend_disp_rdata", bus.vram_disp_rdata, mem[14'h0103]);

        // Address change during STROBE does not disturb the access in flight
        fork
            cpu_acc(1'b0, 14'h0010, 8'h00, lat);
            begin
                repeat (2) @(posedge clk40m);
                #1 bus.vram_cpu_a = 14'h0020;
                @(negedge clk40m);
                chk("hold_sram_a", bus.sram_a, 14'h0010);
                chk("hold_oe_n", bus.sram_oe_n, 0);
            end
        join
        chk("hold_rdata_old", bus.vram_cpu_rdata, 8'h11);

        // Req held after ack: next access follows with no extra gap
        cpu_acc(1'b0, 14'h0020, 8'h00, lat);
        cpu_acc(1'b0, 14'h0800, 8'h00, lat2);
        chk("b2b_gap", lat2, 5);
        chk("b2b_rdata", bus.vram_cpu_rdata, 8'h3C);

        // Reset during STROBE of a write: strobes drop at once, no ack, held req then completes
        bus.vram_cpu_req = 1'b1; bus.vram_cpu_wr = 1'b1;
        bus.vram_cpu_a = 14'h0333; bus.vram_cpu_wdata = 8'h5A;
        repeat (2) @(posedge clk40m);
        #2;
        chk("pre_rst_we_n", bus.sram_we_n, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we_n", bus.sram_we_n, 1);
        chk("mid_rst_d_oe", bus.sram_d_oe, 0);
        chk("mid_rst_ce_n", bus.sram_ce_n, 1);
        @(posedge clk40m); #1;
        chk("mid_rst_no_ack", bus.vram_cpu_ack, 0);
        rst = 1'b0;
        wait_ack(1'b0, lat);
        @(posedge clk40m); #1;
        bus.vram_cpu_req = 1'b0;
        chk("post_rst_latency", lat, 5);
        cpu_acc(1'b0, 14'h0333, 8'h00, lat);
        chk("post_rst_readback", bus.vram_cpu_rdata, 8'h5A);

        repeat (3) @(posedge clk40m);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
